// File: rtl/exu_trap_ctrl.sv
// Commit-stage controller: round-robin ALU/LSU commit arbitration, normal retirement,
// exception sequencing (mepc, mcause, flush to mtvec) and ebreak halt.
module exu_trap_ctrl #(
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_cmt_valid,
    output logic               alu_cmt_ready,
    input  logic [PC_SIZE-1:0] alu_cmt_pc,
    input  logic               alu_cmt_ebreak,
    input  logic               alu_cmt_ecall,
    input  logic               lsu_cmt_valid,
    output logic               lsu_cmt_ready,
    input  logic [PC_SIZE-1:0] lsu_cmt_pc,
    input  logic               lsu_cmt_ld_misa,
    input  logic               lsu_cmt_st_misa,
    input  logic [PC_SIZE-1:0] csr_mtvec,
    output logic               csr_wr_en,
    output logic [11:0]        csr_wr_addr,
    output logic [XLEN-1:0]    csr_wr_data,
    output logic               flush_req,
    output logic [PC_SIZE-1:0] redirect_pc,
    output logic               retire_valid,
    output logic [PC_SIZE-1:0] retire_pc,
    output logic               commit_trap,
    output logic [XLEN-1:0]    cmt_cause
);

    typedef enum logic [2:0] {
        IDLE,
        WR_EPC,
        WR_CAUSE,
        FLUSH,
        HALT
    } state_t;

    typedef enum logic {
        RR_ALU,
        RR_LSU
    } rr_t;

    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [3:0]  CAUSE_EBREAK = 4'd3;
    localparam logic [3:0]  CAUSE_LD_MIS = 4'd4;
    localparam logic [3:0]  CAUSE_ST_MIS = 4'd6;
    localparam logic [3:0]  CAUSE_ECALL  = 4'd11;

    state_t             state;
    state_t             state_nxt;
    rr_t                rr_ptr;
    rr_t                rr_nxt;
    logic [PC_SIZE-1:0] epc;
    logic [3:0]         ecause;

    logic               grant_alu;
    logic               grant_lsu;
    logic [PC_SIZE-1:0] gnt_pc;
    logic               gnt_ebreak;
    logic               gnt_exc;
    logic               gnt_retire;
    logic [3:0]         gnt_cause;

    // Arbitration: only IDLE grants; the round-robin pointer moves only on contention.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        rr_nxt    = rr_ptr;
        if (state == IDLE) begin
            if (alu_cmt_valid && lsu_cmt_valid) begin
                if (rr_ptr == RR_ALU) begin
                    grant_alu = 1'b1;
                    rr_nxt    = RR_LSU;
                end else begin
                    grant_lsu = 1'b1;
                    rr_nxt    = RR_ALU;
                end
            end else begin
                grant_alu = alu_cmt_valid;
                grant_lsu = lsu_cmt_valid;
            end
        end
    end

    assign alu_cmt_ready = grant_alu;
    assign lsu_cmt_ready = grant_lsu;

    always_comb begin
        gnt_pc     = '0;
        gnt_ebreak = 1'b0;
        gnt_exc    = 1'b0;
        gnt_cause  = '0;
        if (grant_alu) begin
            gnt_pc = alu_cmt_pc;
            if (alu_cmt_ebreak) begin
                gnt_ebreak = 1'b1;
                gnt_cause  = CAUSE_EBREAK;
            end else if (alu_cmt_ecall) begin
                gnt_exc   = 1'b1;
                gnt_cause = CAUSE_ECALL;
            end
        end else if (grant_lsu) begin
            gnt_pc = lsu_cmt_pc;
            if (lsu_cmt_ld_misa) begin
                gnt_exc   = 1'b1;
                gnt_cause = CAUSE_LD_MIS;
            end else if (lsu_cmt_st_misa) begin
                gnt_exc   = 1'b1;
                gnt_cause = CAUSE_ST_MIS;
            end
        end
    end

    assign gnt_retire = (grant_alu | grant_lsu) & ~gnt_ebreak & ~gnt_exc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_ebreak) begin
                    state_nxt = HALT;
                end else if (gnt_exc) begin
                    state_nxt = WR_EPC;
                end
            end
            WR_EPC:   state_nxt = WR_CAUSE;
            WR_CAUSE: state_nxt = FLUSH;
            FLUSH:    state_nxt = IDLE;
            HALT:     state_nxt = HALT;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        csr_wr_en   = 1'b0;
        csr_wr_addr = '0;
        csr_wr_data = '0;
        flush_req   = 1'b0;
        redirect_pc = '0;
        case (state)
            WR_EPC: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = CSR_MEPC;
                csr_wr_data = XLEN'(epc);
            end
            WR_CAUSE: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = CSR_MCAUSE;
                csr_wr_data = XLEN'(ecause);
            end
            FLUSH: begin
                flush_req   = 1'b1;
                redirect_pc = {csr_mtvec[PC_SIZE-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= RR_ALU;
            epc          <= '0;
            ecause       <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            commit_trap  <= 1'b0;
            cmt_cause    <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            retire_valid <= gnt_retire;
            if (gnt_retire) begin
                retire_pc <= gnt_pc;
            end
            if (gnt_exc || gnt_ebreak) begin
                epc       <= gnt_pc;
                ecause    <= gnt_cause;
                cmt_cause <= XLEN'(gnt_cause);
            end
            if (gnt_ebreak) begin
                commit_trap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Scoreboard bench for exu_trap_ctrl: a transaction-level model predicts grants and
// queues timed retire/CSR/flush events that a monitor compares against the DUT.
module tb_exu_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_cmt_valid = 1'b0;
    logic        alu_cmt_ready;
    logic [31:0] alu_cmt_pc = '0;
    logic        alu_cmt_ebreak = 1'b0;
    logic        alu_cmt_ecall = 1'b0;
    logic        lsu_cmt_valid = 1'b0;
    logic        lsu_cmt_ready;
    logic [31:0] lsu_cmt_pc = '0;
    logic        lsu_cmt_ld_misa = 1'b0;
    logic        lsu_cmt_st_misa = 1'b0;
    logic [31:0] csr_mtvec = '0;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        flush_req;
    logic [31:0] redirect_pc;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        commit_trap;
    logic [31:0] cmt_cause;

    exu_trap_ctrl #(.PC_SIZE(32), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_cmt_valid   (alu_cmt_valid),
        .alu_cmt_ready   (alu_cmt_ready),
        .alu_cmt_pc      (alu_cmt_pc),
        .alu_cmt_ebreak  (alu_cmt_ebreak),
        .alu_cmt_ecall   (alu_cmt_ecall),
        .lsu_cmt_valid   (lsu_cmt_valid),
        .lsu_cmt_ready   (lsu_cmt_ready),
        .lsu_cmt_pc      (lsu_cmt_pc),
        .lsu_cmt_ld_misa (lsu_cmt_ld_misa),
        .lsu_cmt_st_misa (lsu_cmt_st_misa),
        .csr_mtvec       (csr_mtvec),
        .csr_wr_en       (csr_wr_en),
        .csr_wr_addr     (csr_wr_addr),
        .csr_wr_data     (csr_wr_data),
        .flush_req       (flush_req),
        .redirect_pc     (redirect_pc),
        .retire_valid    (retire_valid),
        .retire_pc       (retire_pc),
        .commit_trap     (commit_trap),
        .cmt_cause       (cmt_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 1 = retire, 2 = CSR write, 3 = flush
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;
    ev_t q[$];

    int vectors = 0;
    int miscompares = 0;

    // Pending requests held by the execution units until accepted.
    bit          a_pend = 0, a_eb = 0, a_ec = 0;
    logic [31:0] a_pc = '0;
    bit          l_pend = 0, l_ld = 0, l_st = 0;
    logic [31:0] l_pc = '0;
    logic [31:0] mtvec_drv = '0;

    // Reference model state.
    int          m_busy = 0;
    bit          m_halt = 0;
    bit          m_trap = 0;
    bit          m_rr = 0;
    logic [31:0] m_cause = '0;
    bit          chk_zero = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_alu(input logic [31:0] pc, input bit eb, input bit ec);
        a_pend = 1; a_pc = pc; a_eb = eb; a_ec = ec;
    endtask

    task automatic set_lsu(input logic [31:0] pc, input bit ld, input bit st);
        l_pend = 1; l_pc = pc; l_ld = ld; l_st = st;
    endtask

    task automatic push_exception(input logic [31:0] pc, input logic [31:0] cause);
        q.push_back('{kind: 2, cyc: cyc + 1, a: 32'h341, b: pc});
        q.push_back('{kind: 2, cyc: cyc + 2, a: 32'h342, b: cause});
        q.push_back('{kind: 3, cyc: cyc + 3, a: 32'h0, b: 32'h0});
        m_busy  = 3;
        m_cause = cause;
    endtask

    task automatic model_step(input bit do_rst);
        bit exp_ra, exp_rl;
        ev_t keep[$];
        exp_ra = 0;
        exp_rl = 0;
        if (!do_rst && !m_halt && m_busy == 0) begin
            if (a_pend && l_pend) begin
                if (m_rr == 0) exp_ra = 1; else exp_rl = 1;
            end else if (a_pend) begin
                exp_ra = 1;
            end else if (l_pend) begin
                exp_rl = 1;
            end
        end
        chk("alu_cmt_ready", alu_cmt_ready, exp_ra);
        chk("lsu_cmt_ready", lsu_cmt_ready, exp_rl);
        chk("commit_trap", commit_trap, m_trap);
        chk("cmt_cause", cmt_cause, m_cause);
        if (chk_zero) begin
            chk("rst_retire_valid", retire_valid, 0);
            chk("rst_retire_pc", retire_pc, 0);
            chk("rst_csr_wr_en", csr_wr_en, 0);
            chk("rst_csr_wr_addr", csr_wr_addr, 0);
            chk("rst_csr_wr_data", csr_wr_data, 0);
            chk("rst_flush_req", flush_req, 0);
            chk("rst_redirect_pc", redirect_pc, 0);
            chk_zero = 0;
        end
        if (do_rst) begin
            foreach (q[i]) if (q[i].cyc <= cyc) keep.push_back(q[i]);
            q = keep;
            m_busy = 0; m_halt = 0; m_trap = 0; m_rr = 0; m_cause = '0;
            a_pend = 0; l_pend = 0;
            chk_zero = 1;
            return;
        end
        if (m_busy > 0) m_busy--;
        if (exp_ra && l_pend) m_rr = 1;
        else if (exp_rl && a_pend) m_rr = 0;
        if (exp_ra) begin
            a_pend = 0;
            if (a_eb) begin
                m_halt = 1; m_trap = 1; m_cause = 32'd3;
            end else if (a_ec) begin
                push_exception(a_pc, 32'd11);
            end else begin
                q.push_back('{kind: 1, cyc: cyc + 1, a: 32'h0, b: a_pc});
            end
        end
        if (exp_rl) begin
            l_pend = 0;
            if (l_ld) push_exception(l_pc, 32'd4);
            else if (l_st) push_exception(l_pc, 32'd6);
            else q.push_back('{kind: 1, cyc: cyc + 1, a: 32'h0, b: l_pc});
        end
    endtask

    task automatic step(input bit do_rst);
        @(posedge clk);
        #1;
        rst             = do_rst;
        alu_cmt_valid   = a_pend && !do_rst;
        alu_cmt_pc      = a_pc;
        alu_cmt_ebreak  = a_eb;
        alu_cmt_ecall   = a_ec;
        lsu_cmt_valid   = l_pend && !do_rst;
        lsu_cmt_pc      = l_pc;
        lsu_cmt_ld_misa = l_ld;
        lsu_cmt_st_misa = l_st;
        csr_mtvec       = mtvec_drv;
        @(negedge clk);
        model_step(do_rst);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        int act_kind, n;
        ev_t e;
        forever begin
            @(negedge clk);
            n = int'(retire_valid === 1'b1) + int'(csr_wr_en === 1'b1) + int'(flush_req === 1'b1);
            if (n > 1) chk("single_event", n, 1);
            act_kind = (retire_valid === 1'b1) ? 1 : (csr_wr_en === 1'b1) ? 2 : (flush_req === 1'b1) ? 3 : 0;
            if (csr_wr_en !== 1'b1) chk("csr_idle_zero", {csr_wr_addr, csr_wr_data}, 0);
            if (flush_req !== 1'b1) chk("redirect_idle_zero", redirect_pc, 0);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("event_kind", act_kind, e.kind);
                if (act_kind == e.kind) begin
                    case (e.kind)
                        1: chk("retire_pc", retire_pc, e.b);
                        2: begin
                            chk("csr_wr_addr", csr_wr_addr, e.a);
                            chk("csr_wr_data", csr_wr_data, e.b);
                        end
                        3: chk("redirect_pc", redirect_pc, {mtvec_drv[31:2], 2'b00});
                        default: ;
                    endcase
                end
            end else if (act_kind != 0) begin
                chk("event_kind", act_kind, 0);
            end
        end
    end

    initial begin
        int halt_n;
        bit r;
        halt_n = 0;
        step(1);
        step(0);
        step(0);

        // Single ALU requester, three back-to-back retirements.
        repeat (3) begin
            if (!a_pend) set_alu(32'h8000_0000, 0, 0);
            step(0);
        end
        repeat (2) step(0);

        // Contention: grants alternate.
        repeat (4) begin
            if (!a_pend) set_alu(32'h8000_0000, 0, 0);
            if (!l_pend) set_lsu(32'h8000_0010, 0, 0);
            step(0);
        end
        repeat (3) step(0);

        // ALU ecall with misaligned mtvec.
        mtvec_drv = 32'h8000_1003;
        set_alu(32'h8000_0100, 0, 1);
        repeat (6) step(0);

        // LSU load+store misaligned; ALU waits behind the sequence.
        set_lsu(32'h8000_0200, 1, 1);
        step(0);
        set_alu(32'h8000_0000, 0, 0);
        repeat (6) step(0);

        // ebreak halts; requests ignored until reset.
        set_alu(32'h8000_0300, 1, 0);
        step(0);
        repeat (20) begin
            if (!a_pend) set_alu($urandom, 0, 0);
            if (!l_pend) set_lsu($urandom, 0, 0);
            mtvec_drv = $urandom;
            step(0);
        end
        step(1);
        step(0);

        // Reset during WR_CAUSE abandons the sequence.
        mtvec_drv = 32'h8000_2000;
        set_alu(32'h8000_0400, 0, 1);
        step(0);
        step(0);
        step(1);
        set_alu(32'h8000_0500, 0, 0);
        repeat (3) step(0);

        // Randomized traffic.
        repeat (3000) begin
            mtvec_drv = $urandom;
            if (!a_pend && $urandom_range(0, 2) != 0)
                set_alu($urandom, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
            if (!l_pend && $urandom_range(0, 2) != 0)
                set_lsu($urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            if (m_halt) halt_n++;
            r = (m_halt && halt_n >= 4) || ($urandom_range(0, 249) == 0);
            if (r) halt_n = 0;
            step(r);
        end

        repeat (12) begin
            mtvec_drv = $urandom;
            step(0);
        end
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
